// File: rtl/pc_sequencer.sv
// Next-PC controller for the 20-bit fetch path: sequential/branch/jump/jr/irq/eret
// selection, one-cycle fetch flush after each redirect, and EPC / in-ISR tracking.
module pc_sequencer #(
    parameter int              PC_W      = 20,
    parameter logic [PC_W-1:0] RESET_VEC = 20'h00000,
    parameter logic [PC_W-1:0] IRQ_VEC   = 20'h00100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_pc,
    input  logic [15:0]     branch_off,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            irq,
    input  logic            eret,
    output logic [PC_W-1:0] next,
    output logic            flush,
    output logic            in_isr,
    output logic [PC_W-1:0] epc
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic            irq_pending;
    logic            take_irq, take_eret, redirect;
    logic [PC_W-1:0] br_tgt;

    assign br_tgt = branch_pc + PC_W'(1) + {{(PC_W-16){branch_off[15]}}, branch_off};
    assign flush  = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            in_isr      <= 1'b0;
            epc         <= '0;
            irq_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            // Acceptance consumes the pending request; otherwise latch any irq level.
            irq_pending <= take_irq ? 1'b0 : (irq_pending | irq);
            if (take_irq) begin
                epc    <= pc;
                in_isr <= 1'b1;
            end else if (take_eret) begin
                in_isr <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (redirect) state_nx = FLUSH;
            FLUSH:   if (!stall)   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Requests in FLUSH belong to the squashed instruction and are ignored.
    always_comb begin
        next      = pc + PC_W'(1);
        take_irq  = 1'b0;
        take_eret = 1'b0;
        redirect  = 1'b0;
        if (rst) begin
            next = RESET_VEC;
        end else if (stall) begin
            next = pc;
        end else if (state == RUN) begin
            if (irq_pending && !in_isr) begin
                next     = IRQ_VEC;
                take_irq = 1'b1;
                redirect = 1'b1;
            end else if (eret && in_isr) begin
                next      = epc;
                take_eret = 1'b1;
                redirect  = 1'b1;
            end else if (jr) begin
                next     = jr_target;
                redirect = 1'b1;
            end else if (jump) begin
                next     = jump_target;
                redirect = 1'b1;
            end else if (branch_taken) begin
                next     = br_tgt;
                redirect = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan walk followed by randomized traffic, both checked against a
// cycle-level model of the next-PC rules; the bench plays the role of the PC register.
module tb_pc_sequencer;
    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc, branch_pc, jump_target, jr_target;
    logic [15:0]  branch_off;
    logic         stall, branch_taken, jump, jr, irq, eret;
    logic [W-1:0] next, epc;
    logic         flush, in_isr;

    int errs = 0;
    int checks = 0;

    // Model state
    logic [W-1:0] mpc, m_epc, exp_next;
    bit           m_isr, m_pend, m_fl;
    int           kind;   // 0: no redirect, 1: irq accept, 2: eret, 3: jr/jump/branch

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_off(branch_off),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .irq(irq), .eret(eret), .next(next), .flush(flush), .in_isr(in_isr), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] wrap(input int v);
        return W'(v & 32'h000F_FFFF);
    endfunction

    task automatic model_next();
        kind = 0;
        if (rst)                    exp_next = '0;
        else if (stall)             exp_next = mpc;
        else if (m_fl)              exp_next = wrap(int'(mpc) + 1);
        else if (m_pend && !m_isr) begin exp_next = 20'h00100; kind = 1; end
        else if (eret && m_isr)    begin exp_next = m_epc;     kind = 2; end
        else if (jr)               begin exp_next = jr_target;  kind = 3; end
        else if (jump)             begin exp_next = jump_target; kind = 3; end
        else if (branch_taken)     begin
            exp_next = wrap(int'(branch_pc) + 1 + int'($signed(branch_off)));
            kind = 3;
        end
        else                        exp_next = wrap(int'(mpc) + 1);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_isr = 0; m_pend = 0; m_fl = 0; m_epc = '0;
        end else begin
            if (kind == 1) begin
                m_epc = mpc; m_isr = 1; m_pend = 0;
            end else begin
                m_pend = m_pend | irq;
            end
            if (kind == 2) m_isr = 0;
            if (!stall) m_fl = (kind != 0);
        end
        mpc = exp_next;
    endtask

    task automatic settle();
        pc = mpc;
        #1;
        model_next();
        chk("next", 32'(next), 32'(exp_next));
        chk("flush", 32'(flush), 32'(m_fl));
        chk("in_isr", 32'(in_isr), 32'(m_isr));
        chk("epc", 32'(epc), 32'(m_epc));
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic clr();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; irq = 0; eret = 0;
    endtask

    initial begin
        clr();
        rst = 1; pc = '0; branch_pc = '0; branch_off = '0; jump_target = '0; jr_target = '0;
        mpc = '0; m_epc = '0; m_isr = 0; m_pend = 0; m_fl = 0; kind = 0; exp_next = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset and sequential run
        repeat (2) begin settle(); chk("rst next", 32'(next), 32'h0); adv(); end
        rst = 0;
        for (int i = 0; i < 4; i++) begin settle(); chk("seq pc", 32'(pc), 32'(i)); adv(); end

        // Branch with negative offset, then flush cycle ignores jump
        branch_taken = 1; branch_pc = 20'h00010; branch_off = 16'hFFFC;
        settle(); chk("br tgt", 32'(next), 32'h0000D); adv();
        clr(); jump = 1; jump_target = 20'h00333;
        settle(); chk("flush on", 32'(flush), 32'h1); chk("flush next", 32'(next), 32'h0000E); adv();
        jump = 0;
        settle(); chk("flush off", 32'(flush), 32'h0); adv();

        // Priority, then the same requests under stall
        jr = 1; jr_target = 20'h00200; jump = 1; branch_taken = 1;
        settle(); chk("prio jr", 32'(next), 32'h00200); adv();
        clr(); step();
        jr = 1; jump = 1; branch_taken = 1; stall = 1;
        settle(); chk("stall next", 32'(next), 32'(mpc)); adv();
        settle(); chk("stall noflush", 32'(flush), 32'h0); adv();
        clr(); step();

        // Interrupt round trip
        mpc = 20'h00040;
        stall = 1; irq = 1; step();
        irq = 0; step(); step();
        stall = 0;
        settle(); chk("irq vec", 32'(next), 32'h00100); adv();
        settle(); chk("epc", 32'(epc), 32'h00040); chk("isr on", 32'(in_isr), 32'h1); adv();
        irq = 1;
        settle(); chk("no nest", 32'(next), 32'(wrap(int'(mpc) + 1))); adv();
        irq = 0; step();
        eret = 1;
        settle(); chk("eret tgt", 32'(next), 32'h00040); adv();
        eret = 0;
        settle(); chk("isr off", 32'(in_isr), 32'h0); chk("eret flush", 32'(next), 32'h00041); adv();
        settle(); chk("pend taken", 32'(next), 32'h00100); adv();
        step();
        eret = 1; step();
        eret = 0; step();

        // Wrap-around
        mpc = 20'hFFFFF;
        settle(); chk("wrap seq", 32'(next), 32'h0); adv();
        branch_taken = 1; branch_pc = 20'hFFFFE; branch_off = 16'h0003;
        settle(); chk("wrap br", 32'(next), 32'h00002); adv();
        clr(); step();

        // Reset during FLUSH with in_isr and a pending irq
        irq = 1; step();
        irq = 0; step();
        step();
        irq = 1; step();
        irq = 0; jump = 1; jump_target = 20'h00500; step();
        jump = 0; rst = 1;
        settle(); chk("pre-rst flush", 32'(flush), 32'h1); chk("pre-rst isr", 32'(in_isr), 32'h1); adv();
        rst = 0;
        settle(); chk("rst flush", 32'(flush), 32'h0); chk("rst isr", 32'(in_isr), 32'h0);
        chk("rst epc", 32'(epc), 32'h0); adv();
        repeat (3) step();
        settle(); chk("no stale irq", 32'(next), 32'(wrap(int'(mpc) + 1))); adv();

        // Randomized traffic
        repeat (500) begin
            rst          = ($urandom_range(0, 49) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            irq          = ($urandom_range(0, 19) == 0);
            eret         = ($urandom_range(0, 9) == 0);
            jr           = ($urandom_range(0, 19) == 0);
            jump         = ($urandom_range(0, 19) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jr_target    = W'($urandom);
            jump_target  = W'($urandom);
            branch_pc    = W'($urandom);
            branch_off   = 16'($urandom);
            if ($urandom_range(0, 9) == 0) mpc = W'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 20-bit MIPS fetch path. It drives the `next` input of the program-counter register each cycle and selects among sequential increment, branch, jump, register-jump, interrupt vector and interrupt return. It also issues a one-cycle fetch flush after every redirect and holds the exception PC (`epc`) and in-ISR state. It sits between the decode/execute stages (control requests) and the PC register (which resets to 0 on its own).

## Interface

- `PC_W`, 20 — PC width; all PC arithmetic is modulo 2^PC_W.
- `RESET_VEC`, 20'h00000 — value driven on `next` while `rst` is high.
- `IRQ_VEC`, 20'h00100 — interrupt handler entry address.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `pc`  in  PC_W  — current PC from the PC register.
- `stall`  in  1  — pipeline stall; hold the PC.
- `branch_taken`  in  1  — resolved taken branch.
- `branch_pc`  in  PC_W  — address of the branch instruction.
- `branch_off`  in  16  — signed word offset.
- `jump`  in  1  — absolute jump request.
- `jump_target`  in  PC_W  — jump destination.
- `jr`  in  1  — register jump request.
- `jr_target`  in  PC_W  — register value.
- `irq`  in  1  — level interrupt request.
- `eret`  in  1  — return from interrupt.
- `next`  out  PC_W  — combinational next PC to the PC register.
- `flush`  out  1  — registered; squash the instruction currently in fetch/decode.
- `in_isr`  out  1  — registered; handler active, further interrupts masked.
- `epc`  out  PC_W  — registered saved return address.

## Operation

- States: `RUN`, `FLUSH`. Reset state is `RUN`.
- Reset values: `flush`=0, `in_isr`=0, `epc`=0, `irq_pending`=0. `next`=RESET_VEC while `rst`=1, regardless of other inputs.
- `irq_pending` is set on any cycle with `irq`=1. It is cleared only when the interrupt is accepted, so a 1-cycle `irq` pulse during a stall is never lost.
- Next-PC selection in `RUN`, first match wins:
  1. `stall` → `next`=`pc`; all requests are ignored. Requesters hold their inputs while stalled.
  2. `irq_pending` && !`in_isr` → `next`=IRQ_VEC, `epc`<=`pc`, `in_isr`<=1, clear pending, redirect.
  3. `eret` && `in_isr` → `next`=`epc`, `in_isr`<=0, redirect.
  4. `jr` → `next`=`jr_target`, redirect.
  5. `jump` → `next`=`jump_target`, redirect.
  6. `branch_taken` → `next`=`branch_pc`+1+sext(`branch_off`), redirect.
  7. Otherwise → `next`=`pc`+1.
- `eret` while !`in_isr` is ignored and treated as sequential.
- A redirect moves the FSM to `FLUSH` with `flush`<=1.
- In `FLUSH`:
  - `flush`=1.
  - All control requests are ignored, because they come from the squashed instruction. This includes `eret`, `jr`, `jump` and `branch_taken`.
  - `irq_pending` is still captured but not accepted.
  - `next`=`pc`+1 → `RUN` with `flush`<=0.
  - If `stall`: `next`=`pc`, remain in `FLUSH` with `flush` held at 1.
- Arithmetic: `branch_off` is sign-extended to PC_W. All sums wrap mod 2^PC_W. `pc`=20'hFFFFF sequential gives `next`=20'h00000.
- Reset mid-operation: on a rising edge with `rst`=1, every register returns to its reset value, including a pending interrupt, an in-progress FLUSH and `in_isr`.

## Timing

- `next` is purely combinational from `pc`, state and the request inputs, with zero latency. The PC register captures it at the same edge that updates this block's state.
- Redirect latency: request in cycle N → `pc`=target in cycle N+1. `flush`=1 in cycle N+1 only, absent stall.
- One bubble per redirect. Back-to-back redirects are impossible because the `FLUSH` cycle ignores requests.
- Interrupt accept latency:
  - 1 cycle after `irq` rises when in `RUN`, unstalled and not `in_isr`.
  - +1 if the block is in `FLUSH`.
  - +k for k stall cycles.
- `epc` and `in_isr` change only at the accept/eret edge and are stable otherwise.

## Test plan

- **Reset and sequential run:** `rst`=1 for 2 cycles, then free run → `next`=0 during reset; `pc` runs 0,1,2,3; `flush`=0, `in_isr`=0, `epc`=0.
- **Branch and flush:**
  - `branch_taken` with `branch_pc`=20'h00010, `branch_off`=16'hFFFC (−4) → `next`=20'h0000D.
  - `flush`=1 for exactly one cycle, during which `jump`=1 is ignored.
  - The cycle after, `next`=20'h0000E.
- **Priority and stall:**
  - `jr`=1 (`jr_target`=20'h00200) plus `jump`=1 plus `branch_taken`=1 in the same cycle → `next`=20'h00200.
  - Repeat with `stall`=1 → `next`=`pc`, no flush.
- **Interrupt round trip:**
  - At `pc`=20'h00040, pulse `irq` for 1 cycle while stalled 3 cycles.
  - After the stall: `next`=20'h00100, `epc`=20'h00040, `in_isr`=1.
  - A second `irq` inside the ISR is not accepted.
  - `eret` → `next`=20'h00040, `in_isr`=0; the pending `irq` is then accepted after the FLUSH cycle.
- **Wrap-around:** `pc`=20'hFFFFF sequential → `next`=0. Branch from `branch_pc`=20'hFFFFE with `branch_off`=3 → `next`=20'h00002.
- **Reset mid-FLUSH/ISR:** assert `rst` during FLUSH with `in_isr`=1 and `irq_pending`=1 → next cycle: `flush`=0, `in_isr`=0, `epc`=0; no interrupt taken after release without a new `irq`.
